// File: rtl/frog_checker_pkg.sv
// ---------------------------------------------------------------------------
// frog_checker_pkg
// Shared definitions for the LFSR sequence checker:
//   - state_e      : acquisition FSM states (IDLE, FILL, SYNC, LOCKED)
//   - *_DEF        : default widths / thresholds used as parameter defaults
// No ports (package).
// ---------------------------------------------------------------------------
package frog_checker_pkg;

  localparam int unsigned N_DEF        = 8;
  localparam int unsigned LOCK_CNT_DEF = 16;
  localparam int unsigned LOSS_CNT_DEF = 4;
  localparam int unsigned ERR_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    SYNC   = 2'd2,
    LOCKED = 2'd3
  } state_e;

endpackage

// File: rtl/frog_predictor.sv
// ---------------------------------------------------------------------------
// frog_predictor
// Holds the tap mask and the N-bit history window of the checked stream and
// predicts the next bit as the XOR of the tapped history bits.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : latch program_i as taps and empty the history window
//   program_i     : tap mask
//   shift_i       : accept one bit into the window this cycle
//   sel_exp_i     : shift in the predicted bit instead of in_i (flywheel)
//   in_i          : received bit
//   exp_o         : predicted next bit (combinational)
//   r_zero_o      : history window is all zero
// ---------------------------------------------------------------------------
module frog_predictor
  import frog_checker_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic [N-1:0] program_i,
  input  logic         shift_i,
  input  logic         sel_exp_i,
  input  logic         in_i,
  output logic         exp_o,
  output logic         r_zero_o
);

  logic [N-1:0] taps_q;
  logic [N-1:0] r_q;
  logic [N-1:0] r_d;
  logic         shift_bit_s;

  assign exp_o    = ^(r_q & taps_q);
  assign r_zero_o = (r_q == '0);

  // Next history window: newest bit enters at the top, r[0] is the oldest.
  always_comb begin
    shift_bit_s = sel_exp_i ? exp_o : in_i;
    if (clear_i) begin
      r_d = '0;
    end else if (shift_i) begin
      r_d = {shift_bit_s, r_q[N-1:1]};
    end else begin
      r_d = r_q;
    end
  end

  // Tap mask and history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q <= '0;
      r_q    <= '0;
    end else begin
      r_q <= r_d;
      if (clear_i) begin
        taps_q <= program_i;
      end
    end
  end

endmodule

// File: rtl/frog_checker.sv
// ---------------------------------------------------------------------------
// frog_checker
// Self-synchronising checker for an LFSR bit stream. After a load it fills
// the history window, waits for LOCK_CNT consecutive correct predictions,
// then flywheels on its own predictions and counts mispredicted bits.
// LOSS_CNT consecutive mispredictions drop lock and restart the fill.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   enable_i      : in_i carries a valid received bit this cycle
//   load_i        : latch program_i as taps and restart acquisition
//   program_i     : tap mask (0 parks the checker in IDLE)
//   in_i          : serial received bit, LSB-first generator output
//   locked_o      : high while locked
//   bit_err_o     : one-cycle pulse per mispredicted bit while locked
//   err_count_o   : saturating count of locked mispredictions
// ---------------------------------------------------------------------------
module frog_checker
  import frog_checker_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF,
  parameter int unsigned LOSS_CNT = LOSS_CNT_DEF,
  parameter int unsigned ERR_W    = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [N-1:0]     program_i,
  input  logic             in_i,
  output logic             locked_o,
  output logic             bit_err_o,
  output logic [ERR_W-1:0] err_count_o
);

  localparam int unsigned FILL_W  = $clog2(N + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

  state_e             state_q;
  logic [FILL_W-1:0]  fill_q;
  logic [MATCH_W-1:0] match_q;
  logic [MISS_W-1:0]  miss_q;
  logic [ERR_W-1:0]   err_q;
  logic               locked_q;
  logic               bit_err_q;

  logic exp_s;
  logic r_zero_s;
  logic accept_s;
  logic match_s;

  // A bit is accepted only outside IDLE and never in a load cycle.
  assign accept_s = enable_i && !load_i && (state_q != IDLE);
  assign match_s  = (in_i == exp_s);

  frog_predictor #(
    .N (N)
  ) u_predictor (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (load_i),
    .program_i (program_i),
    .shift_i   (accept_s),
    .sel_exp_i (state_q == LOCKED),
    .in_i      (in_i),
    .exp_o     (exp_s),
    .r_zero_o  (r_zero_s)
  );

  // Acquisition FSM, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      err_q     <= '0;
      locked_q  <= 1'b0;
      bit_err_q <= 1'b0;
    end else if (load_i) begin
      state_q   <= (program_i != '0) ? FILL : IDLE;
      fill_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      err_q     <= '0;
      locked_q  <= 1'b0;
      bit_err_q <= 1'b0;
    end else begin
      bit_err_q <= 1'b0;
      if (enable_i) begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          FILL: begin
            if (fill_q == FILL_W'(N - 1)) begin
              state_q <= SYNC;
              match_q <= '0;
            end else begin
              fill_q <= fill_q + FILL_W'(1);
            end
          end
          SYNC: begin
            // An all-zero window predicts zeros forever; never let it count.
            if (r_zero_s || !match_s) begin
              match_q <= '0;
            end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              miss_q   <= '0;
            end else begin
              match_q <= match_q + MATCH_W'(1);
            end
          end
          LOCKED: begin
            if (match_s) begin
              miss_q <= '0;
            end else begin
              bit_err_q <= 1'b1;
              if (err_q != {ERR_W{1'b1}}) begin
                err_q <= err_q + ERR_W'(1);
              end
              if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                // Window is kept: refill starts from the flywheel history.
                state_q  <= FILL;
                fill_q   <= '0;
                miss_q   <= '0;
                locked_q <= 1'b0;
              end else begin
                miss_q <= miss_q + MISS_W'(1);
              end
            end
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked_o    = locked_q;
  assign bit_err_o   = bit_err_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_frog_checker.sv
// ---------------------------------------------------------------------------
// tb_frog_checker
// Drives a stream-level reference model and two checker instances (default
// error width and a 3-bit error counter to reach saturation), comparing all
// outputs one time unit after every rising clock edge.
// ---------------------------------------------------------------------------
module tb_frog_checker;

  localparam int N       = 8;
  localparam int LOCK    = 16;
  localparam int LOSS    = 4;
  localparam int ERR_W   = 16;
  localparam int ERR_W_S = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable_i = 1'b0;
  logic             load_i = 1'b0;
  logic [N-1:0]     program_i = '0;
  logic             in_i = 1'b0;
  logic             locked_o, bit_err_o;
  logic [ERR_W-1:0] err_count_o;
  logic             locked_s_o, bit_err_s_o;
  logic [ERR_W_S-1:0] err_count_s_o;

  int checks = 0;
  int errors = 0;

  frog_checker #(.N(N), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(ERR_W)) u_dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .load_i(load_i),
    .program_i(program_i), .in_i(in_i),
    .locked_o(locked_o), .bit_err_o(bit_err_o), .err_count_o(err_count_o)
  );

  frog_checker #(.N(N), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(ERR_W_S)) u_dut_sat (
    .clk(clk), .rst(rst), .enable_i(enable_i), .load_i(load_i),
    .program_i(program_i), .in_i(in_i),
    .locked_o(locked_s_o), .bit_err_o(bit_err_s_o), .err_count_o(err_count_s_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (stream level) ----------------
  // Modes: 0 idle, 1 filling, 2 synchronising, 3 locked.
  int         m_mode;
  bit         m_win[$];      // index 0 = oldest received bit
  bit [N-1:0] m_taps;
  int         m_fill, m_match, m_miss, m_err_raw;
  bit         e_locked, e_bit_err;

  function automatic bit m_predict();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) p = p ^ (m_taps[i] & m_win[i]);
    return p;
  endfunction

  function automatic int sat(int raw, int w);
    int lim = (1 << w) - 1;
    return (raw > lim) ? lim : raw;
  endfunction

  task automatic model_clear_win();
    m_win.delete();
    for (int i = 0; i < N; i++) m_win.push_back(1'b0);
  endtask

  task automatic model_reset();
    m_mode = 0; m_taps = '0; model_clear_win();
    m_fill = 0; m_match = 0; m_miss = 0; m_err_raw = 0;
    e_locked = 1'b0; e_bit_err = 1'b0;
  endtask

  task automatic model_step(bit ld, bit en, bit [N-1:0] prog, bit b);
    bit p, allzero;
    e_bit_err = 1'b0;
    if (ld) begin
      m_taps = prog; model_clear_win();
      m_fill = 0; m_match = 0; m_miss = 0; m_err_raw = 0;
      m_mode = (prog != '0) ? 1 : 0;
    end else if (en && m_mode != 0) begin
      p = m_predict();
      allzero = 1'b1;
      foreach (m_win[i]) if (m_win[i]) allzero = 1'b0;
      m_win.push_back((m_mode == 3) ? p : b);
      void'(m_win.pop_front());
      case (m_mode)
        1: begin
          m_fill++;
          if (m_fill == N) begin m_mode = 2; m_match = 0; end
        end
        2: begin
          if (allzero || b != p) m_match = 0;
          else begin
            m_match++;
            if (m_match == LOCK) begin m_mode = 3; m_miss = 0; end
          end
        end
        default: begin
          if (b == p) m_miss = 0;
          else begin
            e_bit_err = 1'b1; m_err_raw++; m_miss++;
            if (m_miss == LOSS) begin m_mode = 1; m_fill = 0; m_miss = 0; end
          end
        end
      endcase
    end
    e_locked = (m_mode == 3);
  endtask

  // ---------------- stream generator ----------------
  // g holds the next N stream bits, g[0] emitted first; each new bit is the
  // tapped XOR of the current window, so an error-free stream is predictable.
  bit [N-1:0] g, g_taps;

  task automatic gen_bit(output bit o);
    bit nb;
    o  = g[0];
    nb = ^(g & g_taps);
    g  = {nb, g[N-1:1]};
  endtask

  // ---------------- checking ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(load_i, enable_i, program_i, in_i);
    #1;
    check("locked", 32'(locked_o), 32'(e_locked));
    check("bit_err", 32'(bit_err_o), 32'(e_bit_err));
    check("err_count", 32'(err_count_o), 32'(sat(m_err_raw, ERR_W)));
    check("err_count_sat", 32'(err_count_s_o), 32'(sat(m_err_raw, ERR_W_S)));
  endtask

  task automatic do_load(bit [N-1:0] prog, bit en);
    load_i = 1'b1; program_i = prog; enable_i = en; in_i = 1'($urandom_range(1));
    tick();
    load_i = 1'b0; enable_i = 1'b0;
  endtask

  task automatic send(bit b, bit en);
    enable_i = en; in_i = b;
    tick();
    enable_i = 1'b0;
  endtask

  task automatic send_gen(bit flip);
    bit o;
    gen_bit(o);
    send(o ^ flip, 1'b1);
  endtask

  // Load taps 8'hB8 and re-prime the generator; single seed bit sits at the
  // newest end because bit 0 of B8 is untapped and an oldest-only seed
  // would flush to an all-zero stream.
  task automatic restart_b8(bit en);
    do_load(8'hB8, en);
    g_taps = 8'hB8; g = 8'h80;
  endtask

  task automatic acquire(string tag);
    for (int k = 1; k <= 24; k++) begin
      send_gen(1'b0);
      if (k == 23) check({tag, "_pre_lock"}, 32'(locked_o), 32'd0);
      if (k == 24) check({tag, "_lock"}, 32'(locked_o), 32'd1);
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    #12;
    check("reset_locked", 32'(locked_o), 32'd0);
    check("reset_err", 32'(err_count_o), 32'd0);
    rst = 1'b0;

    // No load yet: enabled bits are ignored.
    for (int i = 0; i < 5; i++) send(1'($urandom_range(1)), 1'b1);
    // Zero program parks in IDLE.
    do_load('0, 1'b0);
    for (int i = 0; i < 5; i++) send(1'($urandom_range(1)), 1'b1);

    // Acquisition from a clean B8 stream.
    restart_b8(1'b0);
    acquire("acq");
    check("acq_err", 32'(err_count_o), 32'd0);
    for (int i = 0; i < 8; i++) send_gen(1'b0);

    // Single channel error.
    send_gen(1'b1);
    check("single_pulse", 32'(bit_err_o), 32'd1);
    check("single_count", 32'(err_count_o), 32'd1);
    check("single_locked", 32'(locked_o), 32'd1);
    send_gen(1'b0);
    check("single_pulse_end", 32'(bit_err_o), 32'd0);
    for (int i = 0; i < 10; i++) send_gen(1'b0);
    check("single_hold", 32'(err_count_o), 32'd1);

    // Gating: enable low keeps everything frozen.
    for (int i = 0; i < 10; i++) send(1'($urandom_range(1)), 1'b0);
    check("gate_locked", 32'(locked_o), 32'd1);
    check("gate_err", 32'(err_count_o), 32'd1);
    for (int i = 0; i < 5; i++) send_gen(1'b0);

    // Loss after four consecutive errors, then relock.
    restart_b8(1'b0);
    acquire("acq2");
    for (int k = 1; k <= 4; k++) begin
      send_gen(1'b1);
      if (k == 3) check("loss_still_locked", 32'(locked_o), 32'd1);
    end
    check("loss_unlocked", 32'(locked_o), 32'd0);
    check("loss_count", 32'(err_count_o), 32'd4);
    acquire("relock");
    check("relock_err_kept", 32'(err_count_o), 32'd4);

    // Load with enable high: bit discarded, counters cleared, full reacquire.
    send_gen(1'b1);
    restart_b8(1'b1);
    check("prio_err", 32'(err_count_o), 32'd0);
    check("prio_locked", 32'(locked_o), 32'd0);
    acquire("prio");

    // Lock-up stream never locks.
    restart_b8(1'b0);
    for (int i = 0; i < 200; i++) send(1'b0, 1'b1);
    check("lockup_locked", 32'(locked_o), 32'd0);

    // Asynchronous reset mid-cycle while locked with errors recorded.
    restart_b8(1'b0);
    acquire("acq3");
    send_gen(1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_locked", 32'(locked_o), 32'd0);
    check("async_bit_err", 32'(bit_err_o), 32'd0);
    check("async_err", 32'(err_count_o), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send(1'($urandom_range(1)), 1'b1);

    // Randomised traffic: random taps/windows, gaps, channel errors, loads.
    restart_b8(1'b0);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(399) == 0) begin
        do_load(($urandom_range(9) == 0) ? '0 : N'($urandom), 1'($urandom_range(1)));
        g_taps = program_i;
        g = N'($urandom);
      end else if ($urandom_range(4) == 0) begin
        send(1'($urandom_range(1)), 1'b0);
      end else begin
        send_gen($urandom_range(29) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frog_checker.md
FROG_CHECKER -- requirements
Module: frog_checker

Interface
REQ-001 SHALL have parameter N, default 8, giving the LFSR width (matches the generator width).
REQ-002 SHALL have parameter LOCK_CNT, default 16, giving the consecutive correct predictions needed to lock.
REQ-003 SHALL have parameter LOSS_CNT, default 4, giving the consecutive mispredictions while locked that drop lock.
REQ-004 SHALL have parameter ERR_W, default 16, giving the error counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port enable, input, 1 bit: in is a valid received bit this cycle.
REQ-008 SHALL have port load, input, 1 bit: latch program as taps and restart acquisition.
REQ-009 SHALL have port program, input, N bits: tap mask, same encoding as the generator.
REQ-010 SHALL have port in, input, 1 bit: serial bit stream, LSB-first generator output.
REQ-011 SHALL have port locked, output, 1 bit: high while in LOCKED.
REQ-012 SHALL have port bit_err, output, 1 bit: one-cycle pulse per mispredicted bit while locked.
REQ-013 SHALL have port err_count, output, ERR_W bits: saturating count of locked mispredictions.

Function
REQ-014 SHALL hold a shift register r[N-1:0] that updates on an accepted bit b as r <= {b, r[N-1:1]}, so r[0] is the oldest bit.
REQ-015 SHALL compute the expected bit combinationally as exp = XOR-reduce(r & taps).
REQ-016 SHALL implement the states IDLE, FILL, SYNC and LOCKED; IDLE is the reset state.
REQ-017 On load: taps <= program; r, fill, match and miss counters and err_count <= 0; next state FILL if program != 0, else IDLE.
REQ-018 load SHALL take priority over enable in the same cycle; the bit on in is discarded.
REQ-019 IDLE: enable SHALL be ignored.
REQ-020 FILL: each enable SHALL shift in in and increment fill_cnt; the Nth bit (fill_cnt == N-1) SHALL move the block to SYNC with match_cnt = 0.
REQ-021 SHALL, in SYNC, shift in the received bit on each enable.
REQ-022 SHALL, in SYNC, increment match_cnt on a match (in == exp) and clear match_cnt on a mismatch.
REQ-023 SHALL hold match_cnt at 0 in SYNC while r == 0, so an all-zero lock-up stream never locks.
REQ-024 SHALL, in SYNC, move to LOCKED on a match that occurs when match_cnt == LOCK_CNT-1.
REQ-025 SHALL, in LOCKED, shift in exp rather than in on each enable (flywheel), so a single channel error does not propagate.
REQ-026 SHALL, in LOCKED, clear miss_cnt on a match.
REQ-027 SHALL, in LOCKED, on a mismatch increment miss_cnt, pulse bit_err and increment err_count, which saturates at all-ones.
REQ-028 SHALL, in LOCKED, move to FILL (fill_cnt = 0, r kept) on a mismatch that occurs when miss_cnt == LOSS_CNT-1; that mismatch is still counted.
REQ-029 SHALL register all outputs: locked changes and bit_err pulses the cycle after the deciding enable edge.
REQ-030 bit_err SHALL be high for exactly one cycle per error.
REQ-031 SHALL have no effect on any state when enable is low, except on load.
REQ-032 SHALL clear err_count only on reset or load; leaving LOCKED does not clear it.

Reset
REQ-033 rst high SHALL immediately force state IDLE, taps, r, all counters, locked, bit_err and err_count to 0, regardless of clk or the current operation.
REQ-034 After rst deasserts, the block SHALL need a load before it accepts bits.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, FILL, SYNC, LOCKED) and the default N, LOCK_CNT, LOSS_CNT and ERR_W constants.
REQ-036 A single sub-module, frog_predictor, SHALL hold r and taps, produce exp, and accept a shift-in select (received or expected bit).
REQ-037 The FSM, counters and outputs SHALL live in frog_checker.

Verification (N=8, taps 8'hB8, generator seed 8'h01, defaults)
REQ-038 Reset: rst pulse mid-cycle -> locked=0, bit_err=0, err_count=0 immediately, with no clk edge needed.
REQ-039 Acquire: load 8'hB8, then an error-free generator stream on every cycle -> locked rises the cycle after the 24th enabled bit; err_count=0.
REQ-040 Single error: invert one bit while locked -> one bit_err pulse, err_count=1, locked stays 1, following bits match.
REQ-041 Loss and relock: invert 4 consecutive bits while locked -> err_count=4, locked falls after the 4th; a clean stream then relocks after 24 more bits.
REQ-042 Lock-up: load 8'hB8, feed 200 zero bits -> locked never asserts.
REQ-043 Priority and gating: load with enable high -> bit ignored and counters cleared; enable low for 10 cycles while locked -> no state change.
